// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, default widths and the length clamp helper for seq_det_ctrl.
// Optional timeout support in seq_det_ctrl is enabled with SEQ_DET_TIMEOUT_EN.
package seq_det_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_TO_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clamp_len(input int len, input int pat_w);
        return (len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_det_matcher.sv
// seq_det_matcher: serial history register with valid-bit count and masked compare against the pattern.
// o_match is combinational and reflects the bit being shifted in on this edge.
module seq_det_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic             i_x,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_match
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_vcnt;
    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_vcnt_next;

    always_comb begin
        w_hist_next = (r_hist << 1) | PAT_W'(i_x);
        // valid-bit count only needs to reach PAT_W, so it saturates there
        w_vcnt_next = (r_vcnt == LEN_W'(PAT_W)) ? r_vcnt : r_vcnt + LEN_W'(1);
        w_mask      = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
        o_match = i_shift && (i_len != '0) && (w_vcnt_next >= i_len) &&
                  (((w_hist_next ^ i_pattern) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_vcnt <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_vcnt <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_next;
            r_vcnt <= w_vcnt_next;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with arm/run/stop sequencing and match-count interrupt.
// Define SEQ_DET_TIMEOUT_EN to add a no-match timeout (i_cfg_timeout / o_timeout).
//
//   state   | meaning
//   ST_IDLE | configurable, waiting for start
//   ST_RUN  | sampling bits, counting matches
//   ST_DONE | threshold reached, holding count
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
`ifdef SEQ_DET_TIMEOUT_EN
    ,
    parameter int TO_W  = DEF_TO_W
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_cfg_we,
    input  logic [PAT_W-1:0]             i_cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   i_cfg_len,
    input  logic                         i_cfg_overlap,
    input  logic [CNT_W-1:0]             i_cfg_thresh,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_x_valid,
    input  logic                         i_x,
`ifdef SEQ_DET_TIMEOUT_EN
    input  logic [TO_W-1:0]              i_cfg_timeout,
    output logic                         o_timeout,
`endif
    output logic                         o_z,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_irq,
    output logic [CNT_W-1:0]             o_match_cnt
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_e           r_state, w_state_next;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_z, r_irq, r_busy, r_done;
    logic [CNT_W-1:0] w_cnt_plus;
    logic             w_match, w_clear, w_run_start, w_cnt_inc;
    logic             w_z_next, w_irq_next;
`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0]  r_cfg_to, r_to_cnt, w_to_plus;
    logic             r_timeout, w_to_fire;
`endif

    seq_det_matcher #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_matcher (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_shift   ((r_state == ST_RUN) && i_x_valid),
        .i_clear   (w_clear),
        .i_x       (i_x),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_match   (w_match)
    );

    assign w_cnt_plus = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
`ifdef SEQ_DET_TIMEOUT_EN
    assign w_to_plus  = r_to_cnt + TO_W'(1);
`endif

    always_comb begin
        w_state_next = r_state;
        w_run_start  = 1'b0;
        w_clear      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_z_next     = 1'b0;
        w_irq_next   = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
        w_to_fire    = 1'b0;
`endif
        case (r_state)
            ST_RUN: begin
                // stop discards any match sampled on the same edge
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_match) begin
                    w_z_next  = 1'b1;
                    w_cnt_inc = 1'b1;
                    w_clear   = !r_overlap;
                    if ((r_thresh != '0) && (w_cnt_plus == r_thresh)) begin
                        w_state_next = ST_DONE;
                        w_irq_next   = 1'b1;
                    end
                end
`ifdef SEQ_DET_TIMEOUT_EN
                else if (i_x_valid && (r_cfg_to != '0) && (w_to_plus == r_cfg_to)) begin
                    w_state_next = ST_IDLE;
                    w_to_fire    = 1'b1;
                end
`endif
            end
            default: begin
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (i_start) begin
                    w_state_next = ST_RUN;
                    w_run_start  = 1'b1;
                    w_clear      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_z       <= 1'b0;
            r_irq     <= 1'b0;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_thresh  <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
            r_z     <= w_z_next;
            r_irq   <= w_irq_next;
            if (w_run_start) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= w_cnt_plus;
            end
            if ((r_state == ST_IDLE) && i_cfg_we) begin
                r_pattern <= i_cfg_pattern;
                r_len     <= LEN_W'(clamp_len(int'(i_cfg_len), PAT_W));
                r_overlap <= i_cfg_overlap;
                r_thresh  <= i_cfg_thresh;
            end
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_to  <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if ((r_state == ST_IDLE) && i_cfg_we) begin
                r_cfg_to <= i_cfg_timeout;
            end
            if (w_run_start) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_RUN) && i_x_valid && !i_stop) begin
                r_to_cnt <= w_match ? '0 : w_to_plus;
            end
        end
    end

    assign o_timeout = r_timeout;
`endif

    assign o_z         = r_z;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_irq       = r_irq;
    assign o_match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed plus randomized checks of seq_det_ctrl against a queue-based reference model.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             start = 1'b0, stop = 1'b0, x_valid = 1'b0, x = 1'b0;
    logic             z, busy, done, irq;
    logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_DET_TIMEOUT_EN
    logic [11:0]      cfg_timeout = '0;
    logic             timeout;
`endif

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cfg_we      (cfg_we),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_cfg_overlap (cfg_overlap),
        .i_cfg_thresh  (cfg_thresh),
        .i_start       (start),
        .i_stop        (stop),
        .i_x_valid     (x_valid),
        .i_x           (x),
`ifdef SEQ_DET_TIMEOUT_EN
        .i_cfg_timeout (cfg_timeout),
        .o_timeout     (timeout),
`endif
        .o_z           (z),
        .o_busy        (busy),
        .o_done        (done),
        .o_irq         (irq),
        .o_match_cnt   (match_cnt)
    );

    // reference model: mode 0 idle, 1 running, 2 finished
    int         n_checks = 0, n_errors = 0;
    int         m_mode = 0, m_len = 0, m_thr = 0, m_cnt = 0, m_tocfg = 0, m_tocnt = 0;
    bit         m_q[$];
    logic [7:0] m_pat = '0;
    bit         m_ovl = 0, m_z = 0, m_irq = 0, m_to = 0;
    int         zc = 0, ic = 0;
    bit         stream [15] = '{1,1,0,1,0,1,0,1,1,1,0,1,0,1,0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_thr = 0; m_cnt = 0; m_tocfg = 0; m_tocnt = 0;
        m_pat = '0; m_ovl = 0; m_z = 0; m_irq = 0; m_to = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit v, input bit xb, input bit st, input bit sp, input bit we);
        bit hit;
        m_z = 0; m_irq = 0; m_to = 0;
        if (m_mode == 1) begin
            if (sp) m_mode = 0;
            else if (v) begin
                m_q.push_back(xb);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                hit = (m_len > 0) && (m_q.size() >= m_len);
                for (int i = 0; i < m_len; i++)
                    if (hit && m_q[m_q.size()-1-i] != m_pat[i]) hit = 0;
                if (hit) begin
                    m_z = 1;
                    if (m_cnt < 65535) m_cnt++;
                    if (!m_ovl) m_q.delete();
                    m_tocnt = 0;
                    if (m_thr != 0 && m_cnt == m_thr) begin m_mode = 2; m_irq = 1; end
                end else begin
                    m_tocnt = (m_tocnt + 1) % 4096;
                    if (m_tocfg != 0 && m_tocnt == m_tocfg) begin m_mode = 0; m_to = 1; end
                end
            end
        end else begin
            if (m_mode == 0 && we) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
                m_ovl = cfg_overlap;
                m_thr = int'(cfg_thresh);
`ifdef SEQ_DET_TIMEOUT_EN
                m_tocfg = int'(cfg_timeout);
`endif
            end
            if (sp) m_mode = 0;
            else if (st) begin m_mode = 1; m_q.delete(); m_cnt = 0; m_tocnt = 0; end
        end
    endtask

    task automatic cyc(input bit v, input bit xb, input bit st, input bit sp, input bit we);
        x_valid = v; x = xb; start = st; stop = sp; cfg_we = we;
        @(posedge clk);
        model_edge(v, xb, st, sp, we);
        #1;
        chk("z", z, m_z);
        chk("irq", irq, m_irq);
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_mode == 2);
        chk("match_cnt", match_cnt, m_cnt);
`ifdef SEQ_DET_TIMEOUT_EN
        chk("timeout", timeout, m_to);
`endif
        if (z) zc++;
        if (irq) ic++;
        x_valid = 0; x = 0; start = 0; stop = 0; cfg_we = 0;
    endtask

    task automatic setcfg(input logic [7:0] p, input logic [3:0] l, input bit o, input logic [15:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_thresh = t;
    endtask

    task automatic run_stream();
        zc = 0; ic = 0;
        for (int i = 0; i < 15; i++) cyc(1, stream[i], 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_z", z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cnt", match_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // overlapping detection, config written together with start
        setcfg(8'b1010, 4, 1, 0);
        cyc(0, 0, 1, 0, 1);
        run_stream();
        chk("ovl_zcount", zc, 4);
        chk("ovl_cnt", match_cnt, 4);
        chk("ovl_busy", busy, 1);
        cyc(0, 0, 0, 1, 0);

        // non-overlapping
        setcfg(8'b1010, 4, 0, 0);
        cyc(0, 0, 1, 0, 1);
        run_stream();
        chk("novl_zcount", zc, 2);
        chk("novl_cnt", match_cnt, 2);
        cyc(0, 0, 0, 1, 0);

        // threshold ends the run after the third match
        setcfg(8'b1010, 4, 1, 3);
        cyc(0, 0, 1, 0, 1);
        run_stream();
        chk("thr_irqcount", ic, 1);
        chk("thr_zcount", zc, 3);
        chk("thr_done", done, 1);
        chk("thr_cnt", match_cnt, 3);
        cyc(0, 0, 1, 0, 0);
        chk("thr_restart_cnt", match_cnt, 0);
        chk("thr_restart_busy", busy, 1);
        cyc(0, 0, 0, 1, 0);

        // stop on the edge that samples bit 7
        setcfg(8'b1010, 4, 1, 0);
        cyc(0, 0, 1, 0, 1);
        zc = 0;
        for (int i = 0; i < 6; i++) cyc(1, stream[i], 0, 0, 0);
        cyc(1, stream[6], 0, 1, 0);
        chk("stop_zcount", zc, 1);
        chk("stop_cnt", match_cnt, 1);
        chk("stop_busy", busy, 0);
        cyc(0, 0, 1, 1, 0);
        chk("startstop_busy", busy, 0);

        // config writes during a run are ignored
        cyc(0, 0, 1, 0, 0);
        setcfg(8'b0110, 4, 1, 0);
        cyc(0, 0, 0, 0, 1);
        zc = 0;
        cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        chk("cfgrun_zcount", zc, 1);

        // gaps in x_valid do not disturb the history
        cyc(0, 0, 0, 1, 0);
        setcfg(8'b1010, 4, 0, 0);
        cyc(0, 0, 1, 0, 1);
        zc = 0;
        cyc(1, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("gap_zcount", zc, 1);

        // length zero never matches; oversize length clamps to full width
        cyc(0, 0, 0, 1, 0);
        setcfg(8'h00, 0, 1, 0);
        cyc(0, 0, 1, 0, 1);
        zc = 0;
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        chk("len0_zcount", zc, 0);
        cyc(0, 0, 0, 1, 0);
        setcfg(8'hA5, 4'd12, 1, 0);
        cyc(0, 0, 1, 0, 1);
        zc = 0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] p;
            p = 8'hA5;
            cyc(1, p[i], 0, 0, 0);
        end
        chk("clamp_zcount", zc, 1);

        // asynchronous reset in the middle of a run
        cyc(0, 0, 0, 1, 0);
        setcfg(8'b1010, 4, 1, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst_z", z, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_cnt", match_cnt, 0);
        @(negedge clk);
        rst_n = 1;

`ifdef SEQ_DET_TIMEOUT_EN
        setcfg(8'b1010, 4, 1, 0);
        cfg_timeout = 12'd5;
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk("to_busy_before", busy, 1);
        cyc(1, 0, 0, 0, 0);
        chk("to_pulse", timeout, 1);
        chk("to_busy_after", busy, 0);
        cfg_timeout = 12'd0;
`endif

        // randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            setcfg(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 16'($urandom_range(0, 4)));
`ifdef SEQ_DET_TIMEOUT_EN
            cfg_timeout = 12'($urandom_range(0, 12));
`endif
            if (r % 2 == 0) setcfg(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom), 16'($urandom_range(0, 4)));
            cyc(0, 0, 1, 0, 1);
            for (int i = 0; i < 60; i++)
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
                    $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 9) == 0);
            cyc(0, 0, 0, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable serial pattern-detection controller; generalises the fixed 1010 detector.
- Holds the pattern/length/overlap configuration and sequences arm/run/stop.
- Qualifies serial bits with x_valid, counts matches and raises a completion interrupt after a programmable threshold.
- Sits between the serial bit source and the system control/interrupt logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 16, match counter / threshold width
- TO_W, 12, timeout counter width (used only with SEQ_DET_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe; honoured only in IDLE
- cfg_pattern  in  PAT_W  pattern; bit 0 = last (most recent) bit
- cfg_len  in  $clog2(PAT_W+1)  pattern length in bits
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match
- cfg_thresh  in  CNT_W  match count that ends the run; 0 = never ends
- start  in  1  level-sampled start request
- stop  in  1  level-sampled abort request
- x_valid  in  1  x carries a bit this cycle
- x  in  1  serial data bit
- z  out  1  one-cycle match pulse
- busy  out  1  high in RUN
- done  out  1  high in DONE
- irq  out  1  one-cycle pulse on entry to DONE
- match_cnt  out  CNT_W  matches in current/last run

Behaviour:
- Reset (async, rst_n=0): state IDLE; z=0, busy=0, done=0, irq=0, match_cnt=0; pattern=0, len=0, overlap=0, thresh=0; history cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we latches all cfg_* fields at the edge.
  - start=1: next state RUN; history and valid-bit count cleared; match_cnt cleared.
  - If cfg_we and start are both high, the new config is used for the run.
- RUN:
  - Each edge with x_valid=1 shifts x into a PAT_W history register.
  - Match condition: the newest cfg_len bits (including the current x) equal cfg_pattern[cfg_len-1:0], and at least cfg_len valid bits have been shifted since the last clear.
  - On match, z is registered high for the cycle after the sampling edge (latency 1 cycle), then returns to 0.
  - Edges with x_valid=0 change nothing.
  - cfg_overlap=0: on a match, history and valid-bit count are cleared; the matching bit is not reused.
  - match_cnt increments on each match and saturates at all-ones.
  - If thresh!=0 and the incremented count equals thresh: next state DONE, irq=1 for one cycle, z for that match still pulses.
  - stop=1: next state IDLE; match_cnt held; any match on that same edge is discarded (no z, no count).
  - start in RUN is ignored.
- DONE:
  - done=1; match_cnt held; x ignored.
  - start: next state RUN with the count and history cleared.
  - stop: next state IDLE.
- start and stop high together: stop wins in every state.
- cfg_len=0: never matches.
- cfg_len>PAT_W: clamped to PAT_W at latch.
- cfg_we outside IDLE is ignored; config is stable during a run.
- busy = (state==RUN); done = (state==DONE); both registered.
- rst_n asserted mid-run: immediate return to reset values; no irq.

Optional Feature:
- Macro SEQ_DET_TIMEOUT_EN.
- Defined:
  - Adds input cfg_timeout[TO_W-1:0] (latched with cfg_we) and output timeout (1 bit, reset 0).
  - In RUN, a counter counts x_valid bits since the last match or since start.
  - When the counter reaches cfg_timeout (nonzero), the block moves to IDLE and pulses timeout for one cycle.
  - A match on that same edge wins and resets the counter instead.
  - cfg_timeout=0 disables the timeout.
- Undefined: no extra ports, no timeout logic.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE, RUN, DONE)
  - default PAT_W/CNT_W/TO_W localparams
  - function clamp_len
- Sub-module seq_det_matcher: history shift register, valid-bit count, masked compare, clear input; outputs a combinational match.
- seq_det_ctrl owns the FSM, config registers, counters and outputs.

Test Plan:
- Overlap count: cfg pattern=8'b1010, len=4, overlap=1, thresh=0; start; stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 with x_valid=1 -> z after bits 5,7,13,15; match_cnt=4; busy stays 1.
- Non-overlap: same stream with overlap=0 -> z after bits 5 and 13 only; match_cnt=2.
- Threshold: overlap=1, thresh=3; same stream -> irq and DONE after bit 13; done=1; bit 15 ignored; match_cnt=3; start returns to RUN with count 0.
- Stop/start precedence: stop on the edge sampling bit 7 -> no z, match_cnt=1, state IDLE. start+stop together in IDLE -> stays IDLE. cfg_we in RUN -> pattern unchanged.
- Gaps and reset: x_valid toggled 1/0 during 1010 -> single match; rst_n low mid-run -> all outputs 0 within the same cycle, no irq.
- SEQ_DET_TIMEOUT_EN: cfg_timeout=5, stream of 0s -> timeout pulse on the 5th valid bit, state IDLE.
